// File: rtl/mib_pkg.sv
// Shared definitions for the MIB command path: bus widths, ack timeout,
// timeout read-data pattern, arbiter state encoding and the command record.
package mib_pkg;

  localparam int MIB_ADDR_BITS        = 26;
  localparam int MIB_DATA_BITS        = 32;
  localparam int CMD_ACK_TIMEOUT_CLKS = 16;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Arbiter sequencing states; IDLE is encoded as 0 so reset shows 0 on debug.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  // One MIB command as presented by a requester.
  typedef struct packed {
    logic                     rd_wr_n;
    logic [MIB_ADDR_BITS-1:0] addr;
    logic [MIB_DATA_BITS-1:0] wdata;
  } mib_cmd_t;

endpackage

// File: rtl/mib_rr_pick.sv
// Combinational round-robin select: first pending requester at or after
// rr_ptr, wrapping around NUM_REQ.
module mib_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] pend,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  localparam int SW = IDX_W + 1;

  logic [SW-1:0] sum;

  // Scan from the farthest offset down so the nearest pending bit wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + SW'(i);
      if (sum >= SW'(NUM_REQ)) begin
        sum = sum - SW'(NUM_REQ);
      end
      if (pend[sum[IDX_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = sum[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mib_cmd_arb.sv
// Round-robin arbiter/sequencer sharing the MIB command port between
// requesters, with an ack timeout and per-requester completion status.
//
// Handshake: a requester pulses req_vld for one cycle and holds its fields
// until req_busy drops; req_ack (with req_err on timeout) pulses for one cycle
// at completion. On the bus side cmd_vld stays high until cmd_ack is sampled
// high or the timeout expires; cmd_ack outside the WAIT state is ignored.
module mib_cmd_arb
  import mib_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int ADDR_BITS        = mib_pkg::MIB_ADDR_BITS,
  parameter int DATA_BITS        = mib_pkg::MIB_DATA_BITS,
  parameter int ACK_TIMEOUT_CLKS = mib_pkg::CMD_ACK_TIMEOUT_CLKS,
  parameter logic [DATA_BITS-1:0] TIMEOUT_RDATA = DATA_BITS'(mib_pkg::TIMEOUT_RDATA)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_vld,
  input  logic [NUM_REQ-1:0]             req_rd_wr_n,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_busy,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic [NUM_REQ-1:0]             req_err,
  output logic [DATA_BITS-1:0]           req_rdata,
  output logic                           cmd_vld,
  output logic                           cmd_rd_wr_n,
  output logic [ADDR_BITS-1:0]           cmd_addr,
  output logic [DATA_BITS-1:0]           cmd_wdata,
  input  logic                           cmd_ack,
  input  logic [DATA_BITS-1:0]           cmd_rdata,
  output logic [1:0]                     dbg_state
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W = $clog2(ACK_TIMEOUT_CLKS + 1);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   pend_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     grant_q;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [TMO_W-1:0]     tmo_cnt_q;
  logic                 tmo_hit;
  logic                 err_q;
  logic [DATA_BITS-1:0] rdata_q;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [NUM_REQ-1:0]   done_oh;
  logic [NUM_REQ-1:0]   grant_clr;
  logic [NUM_REQ-1:0]   done_clr;
  logic                 sel_rd_wr_n;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_BITS-1:0] sel_wdata;

  mib_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .pend      (pend_q),
    .rr_ptr    (rr_ptr_q),
    .grant_idx (pick_idx),
    .grant_any (pick_any)
  );

  assign tmo_hit   = (tmo_cnt_q == TMO_W'(ACK_TIMEOUT_CLKS - 1));
  assign pick_oh   = NUM_REQ'(1) << pick_idx;
  assign done_oh   = NUM_REQ'(1) << grant_q;
  assign grant_clr = (state_q == ARB_IDLE && pick_any) ? pick_oh : '0;
  assign done_clr  = (state_q == ARB_DONE) ? done_oh : '0;
  assign dbg_state = state_q;

  // Mux the picked requester's command fields for capture at grant.
  always_comb begin
    sel_rd_wr_n = 1'b0;
    sel_addr    = '0;
    sel_wdata   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_rd_wr_n = req_rd_wr_n[i];
        sel_addr    = req_addr[i*ADDR_BITS +: ADDR_BITS];
        sel_wdata   = req_wdata[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // Next-state logic; ack takes precedence over a coincident timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (pick_any) state_d = ARB_ISSUE;
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT:  if (cmd_ack || tmo_hit) state_d = ARB_DONE;
      ARB_DONE:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // Pending and busy bookkeeping; strobes from busy requesters are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '0;
      req_busy <= '0;
    end else begin
      pend_q   <= (pend_q | (req_vld & ~req_busy)) & ~grant_clr;
      req_busy <= (req_busy | req_vld) & ~done_clr;
    end
  end

  // Command capture, bus drive, timeout counting and completion reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      tmo_cnt_q   <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      cmd_vld     <= 1'b0;
      cmd_rd_wr_n <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      req_ack     <= '0;
      req_err     <= '0;
      req_rdata   <= '0;
    end else begin
      req_ack   <= '0;
      req_err   <= '0;
      req_rdata <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_q     <= pick_idx;
            cmd_rd_wr_n <= sel_rd_wr_n;
            cmd_addr    <= sel_addr;
            cmd_wdata   <= sel_wdata;
          end
        end
        ARB_ISSUE: begin
          cmd_vld   <= 1'b1;
          tmo_cnt_q <= '0;
          err_q     <= 1'b0;
        end
        ARB_WAIT: begin
          if (cmd_ack) begin
            cmd_vld <= 1'b0;
            rdata_q <= cmd_rdata;
            err_q   <= 1'b0;
          end else if (tmo_hit) begin
            cmd_vld <= 1'b0;
            rdata_q <= TIMEOUT_RDATA;
            err_q   <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        ARB_DONE: begin
          req_ack   <= done_oh;
          req_err   <= err_q ? done_oh : '0;
          req_rdata <= cmd_rd_wr_n ? rdata_q : '0;
          rr_ptr_q  <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mib_cmd_arb.sv
// Directed bench for mib_cmd_arb with two requesters.
module tb_mib_cmd_arb;

  localparam int NR = 2;
  localparam int AB = 26;
  localparam int DB = 32;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req_vld;
  logic [NR-1:0]    req_rd_wr_n;
  logic [NR*AB-1:0] req_addr;
  logic [NR*DB-1:0] req_wdata;
  logic [NR-1:0]    req_busy;
  logic [NR-1:0]    req_ack;
  logic [NR-1:0]    req_err;
  logic [DB-1:0]    req_rdata;
  logic             cmd_vld;
  logic             cmd_rd_wr_n;
  logic [AB-1:0]    cmd_addr;
  logic [DB-1:0]    cmd_wdata;
  logic             cmd_ack;
  logic [DB-1:0]    cmd_rdata;
  logic [1:0]       dbg_state;

  int n_pass  = 0;
  int n_total = 0;
  int hi_cnt;

  mib_cmd_arb #(.NUM_REQ(NR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_vld     (req_vld),
    .req_rd_wr_n (req_rd_wr_n),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_busy    (req_busy),
    .req_ack     (req_ack),
    .req_err     (req_err),
    .req_rdata   (req_rdata),
    .cmd_vld     (cmd_vld),
    .cmd_rd_wr_n (cmd_rd_wr_n),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .cmd_ack     (cmd_ack),
    .cmd_rdata   (cmd_rdata),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_req(input int n, input logic rd, input logic [AB-1:0] a, input logic [DB-1:0] d);
    req_rd_wr_n[n]       = rd;
    req_addr[n*AB +: AB] = a;
    req_wdata[n*DB +: DB] = d;
  endtask

  // One-cycle request strobe; returns just after the edge that samples it.
  task automatic pulse_req(input logic [NR-1:0] m);
    req_vld = m;
    tick();
    req_vld = '0;
  endtask

  // One-cycle slave ack; returns just after the edge that samples it.
  task automatic ack_pulse(input logic [DB-1:0] d);
    cmd_rdata = d;
    cmd_ack   = 1'b1;
    tick();
    cmd_ack   = 1'b0;
    cmd_rdata = '0;
  endtask

  initial begin
    rst_n       = 1'b0;
    req_vld     = '0;
    req_rd_wr_n = '0;
    req_addr    = '0;
    req_wdata   = '0;
    cmd_ack     = 1'b0;
    cmd_rdata   = '0;
    repeat (3) tick();

    // Reset state.
    check("rst_busy", req_busy, 0);
    check("rst_ack", req_ack, 0);
    check("rst_err", req_err, 0);
    check("rst_rdata", req_rdata, 0);
    check("rst_cmd_vld", cmd_vld, 0);
    check("rst_cmd_addr", cmd_addr, 0);
    check("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    tick();

    // Single write from requester 0, slave acks after 3 cycles.
    set_req(0, 1'b0, 26'h100_0000, 32'h1234_5678);
    pulse_req(2'b01);
    check("wr_busy_set", req_busy, 2'b01);
    check("wr_vld_e0", cmd_vld, 0);
    tick();
    check("wr_state_issue", dbg_state, 1);
    check("wr_vld_e1", cmd_vld, 0);
    tick();
    check("wr_vld_e2", cmd_vld, 1);
    check("wr_addr", cmd_addr, 26'h100_0000);
    check("wr_wdata", cmd_wdata, 32'h1234_5678);
    check("wr_dir", cmd_rd_wr_n, 0);
    tick();
    tick();
    check("wr_vld_hold", cmd_vld, 1);
    check("wr_no_early_ack", req_ack, 0);
    ack_pulse(32'h0000_0000);
    check("wr_vld_drop", cmd_vld, 0);
    check("wr_ack_k", req_ack, 0);
    tick();
    check("wr_ack", req_ack, 2'b01);
    check("wr_err", req_err, 0);
    check("wr_rdata_zero", req_rdata, 0);
    check("wr_busy_clr", req_busy, 0);
    tick();
    check("wr_ack_one_cycle", req_ack, 0);
    check("wr_idle", dbg_state, 0);

    // Single read from requester 1.
    set_req(1, 1'b1, 26'h110_0000, 32'h0);
    pulse_req(2'b10);
    tick();
    tick();
    check("rd_vld", cmd_vld, 1);
    check("rd_addr", cmd_addr, 26'h110_0000);
    check("rd_dir", cmd_rd_wr_n, 1);
    ack_pulse(32'hCAFE_F00D);
    tick();
    check("rd_ack", req_ack, 2'b10);
    check("rd_rdata", req_rdata, 32'hCAFE_F00D);
    check("rd_err", req_err, 0);
    tick();

    // Contention with rr_ptr = 0: requester 0 first, then requester 1.
    set_req(0, 1'b0, 26'h000_0A00, 32'hAAAA_0000);
    set_req(1, 1'b1, 26'h000_0B00, 32'h0);
    pulse_req(2'b11);
    check("c1_busy", req_busy, 2'b11);
    tick();
    tick();
    check("c1_first_addr", cmd_addr, 26'h000_0A00);
    ack_pulse(32'h0);
    tick();
    check("c1_first_ack", req_ack, 2'b01);
    check("c1_busy_after_first", req_busy, 2'b10);
    tick();
    check("c1_gap", cmd_vld, 0);
    tick();
    check("c1_second_vld", cmd_vld, 1);
    check("c1_second_addr", cmd_addr, 26'h000_0B00);
    ack_pulse(32'h1357_9BDF);
    tick();
    check("c1_second_ack", req_ack, 2'b10);
    check("c1_second_rdata", req_rdata, 32'h1357_9BDF);
    tick();

    // Timeout: requester 0 read with no slave ack.
    set_req(0, 1'b1, 26'h120_0000, 32'h0);
    pulse_req(2'b01);
    tick();
    tick();
    hi_cnt = cmd_vld ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cmd_vld) hi_cnt++;
      else break;
    end
    check("tmo_vld_cycles", hi_cnt, 16);
    check("tmo_ack_not_yet", req_ack, 0);
    tick();
    check("tmo_ack", req_ack, 2'b01);
    check("tmo_err", req_err, 2'b01);
    check("tmo_rdata", req_rdata, 32'hDEAD_BEEF);
    tick();
    check("tmo_err_one_cycle", req_err, 0);

    // Contention with rr_ptr = 1: requester 1 first this time.
    set_req(0, 1'b0, 26'h000_0C00, 32'hCCCC_0000);
    set_req(1, 1'b0, 26'h000_0D00, 32'hDDDD_0000);
    pulse_req(2'b11);
    tick();
    tick();
    check("c2_first_addr", cmd_addr, 26'h000_0D00);
    check("c2_first_wdata", cmd_wdata, 32'hDDDD_0000);
    ack_pulse(32'h0);
    tick();
    check("c2_first_ack", req_ack, 2'b10);
    tick();
    tick();
    check("c2_second_addr", cmd_addr, 26'h000_0C00);
    ack_pulse(32'h0);
    tick();
    check("c2_second_ack", req_ack, 2'b01);
    tick();

    // Ack on the 16th cmd_vld cycle beats the timeout.
    set_req(1, 1'b1, 26'h130_0000, 32'h0);
    pulse_req(2'b10);
    tick();
    tick();
    repeat (15) tick();
    check("late_vld_still_high", cmd_vld, 1);
    ack_pulse(32'h5A5A_1234);
    check("late_vld_drop", cmd_vld, 0);
    tick();
    check("late_ack", req_ack, 2'b10);
    check("late_err", req_err, 0);
    check("late_rdata", req_rdata, 32'h5A5A_1234);
    tick();

    // Stray ack while idle.
    ack_pulse(32'hFFFF_FFFF);
    check("stray_vld", cmd_vld, 0);
    tick();
    check("stray_ack", req_ack, 0);
    check("stray_state", dbg_state, 0);
    tick();
    check("stray_ack2", req_ack, 0);

    // Reset in WAIT with one request in flight and one pending.
    set_req(0, 1'b0, 26'h000_0E00, 32'hEEEE_0000);
    set_req(1, 1'b0, 26'h000_0F00, 32'hFFFF_0000);
    pulse_req(2'b11);
    tick();
    tick();
    tick();
    check("rstw_vld_before", cmd_vld, 1);
    check("rstw_state_wait", dbg_state, 2);
    rst_n = 1'b0;
    #1;
    check("rstw_vld_async", cmd_vld, 0);
    check("rstw_busy", req_busy, 0);
    tick();
    tick();
    check("rstw_no_ack", req_ack, 0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("rstw_no_regrant", cmd_vld, 0);
    check("rstw_busy_after", req_busy, 0);
    check("rstw_ack_after", req_ack, 0);

    // Normal transaction after reset release.
    set_req(1, 1'b0, 26'h140_0000, 32'h7777_8888);
    pulse_req(2'b10);
    tick();
    tick();
    check("post_vld", cmd_vld, 1);
    check("post_addr", cmd_addr, 26'h140_0000);
    check("post_wdata", cmd_wdata, 32'h7777_8888);
    ack_pulse(32'h0);
    tick();
    check("post_ack", req_ack, 2'b10);
    check("post_busy", req_busy, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
